// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enable single-port RAM and its clear sequencer.
// Holds the read-during-write mode codes, the sequencer state encoding and the byte-lane merge helper.
package mem_pkg;

   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   // One byte lane of a partial write: the new byte where enabled, the old byte elsewhere.
   function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       be);
      return be ? new_b : old_b;
   endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer for ram_sp_be: sweeps zeros through the whole array after reset or on request,
// and muxes the array write port between that sweep and the user port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | sweep owns the array; writes 0 to address cnt each cycle
//   ST_IDLE  | user port owns the array; clr_req starts a new sweep
module ram_clr_seq
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH)
)
(
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  clr_req,
   input  logic [DATA_W/8-1:0]   user_be,
   input  logic [ADDR_W-1:0]     user_addr,
   input  logic [DATA_W-1:0]     user_data,
   output logic                  busy,
   output logic [DATA_W/8-1:0]   wr_be,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_W-1:0]     wr_data
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   clr_state_e        state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         ST_CLEAR: begin
            if (cnt == LAST_ADDR) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            // the user access of this cycle still goes through; the sweep begins next edge
            if (clr_req) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy = (state == ST_CLEAR);

   always_comb begin
      wr_be   = user_be;
      wr_addr = user_addr;
      wr_data = user_data;
      if (busy) begin
         wr_be   = {NB{1'b1}};
         wr_addr = cnt;
         wr_data = '0;
      end
   end

endmodule

// File: rtl/ram_sp_be.sv
// Parametrised single-port synchronous RAM with byte write enables, selectable read-during-write
// behaviour, optional second output register and a built-in clear sweep.
module ram_sp_be
   import mem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 128,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int WRITE_MODE = WM_READ_FIRST,
   parameter int OUT_REG    = 0
)
(
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  ena,
   input  logic [DATA_W/8-1:0]   wea,
   input  logic [ADDR_W-1:0]     addra,
   input  logic [DATA_W-1:0]     dina,
   output logic [DATA_W-1:0]     douta,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              addr_ok;
   logic              user_acc;
   logic [NB-1:0]     user_be;
   logic [NB-1:0]     wr_be;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] rd_q, rd_nxt;

   // Out-of-range addresses exist only when DEPTH is not a power of two.
   assign addr_ok  = ({1'b0, addra} < DEPTH_V);
   assign user_acc = ena & ~busy;
   assign user_be  = (ena && addr_ok) ? wea : '0;

   ram_clr_seq #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clka      (clka),
      .rsta      (rsta),
      .clr_req   (clr_req),
      .user_be   (user_be),
      .user_addr (addra),
      .user_data (dina),
      .busy      (busy),
      .wr_be     (wr_be),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   always_ff @(posedge clka) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   assign old_word = addr_ok ? mem[addra] : '0;

   for (genvar g = 0; g < NB; g++) begin : g_merge
      assign merged[8*g +: 8] = byte_merge(old_word[8*g +: 8], dina[8*g +: 8], wea[g]);
   end

   always_comb begin
      rd_nxt = rd_q;
      if (user_acc) begin
         if (WRITE_MODE == WM_WRITE_FIRST) begin
            rd_nxt = addr_ok ? merged : '0;
         end else if (WRITE_MODE == WM_NO_CHANGE) begin
            if (wea == '0) rd_nxt = old_word;
         end else begin
            rd_nxt = old_word;
         end
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) rd_q <= '0;
      else      rd_q <= rd_nxt;
   end

   // The second stage shifts every cycle, so it simply re-captures a held first stage.
   if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clka or posedge rsta) begin
         if (rsta) out_q <= '0;
         else      out_q <= rd_q;
      end
      assign douta = out_q;
   end else begin : g_noreg
      assign douta = rd_q;
   end

endmodule

// File: tb/tb_ram_sp_be.sv
// Bench for ram_sp_be: three instances (READ_FIRST/128, WRITE_FIRST+OUT_REG/128, NO_CHANGE/100)
// share one stimulus stream and are compared every cycle against a word-array model.
module tb_ram_sp_be;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic        clr_req = 1'b0;
   logic [3:0]  wea = 4'h0;
   logic [6:0]  addr = 7'h0;
   logic [31:0] din = 32'h0;

   logic [31:0] dout0, dout1, dout2;
   logic        busy0, busy1, busy2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_sp_be #(.DEPTH(128), .WRITE_MODE(0), .OUT_REG(0)) u0 (
      .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addr), .dina(din),
      .douta(dout0), .clr_req(clr_req), .busy(busy0));
   ram_sp_be #(.DEPTH(128), .WRITE_MODE(1), .OUT_REG(1)) u1 (
      .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addr), .dina(din),
      .douta(dout1), .clr_req(clr_req), .busy(busy1));
   ram_sp_be #(.DEPTH(100), .WRITE_MODE(2), .OUT_REG(0)) u2 (
      .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addr), .dina(din),
      .douta(dout2), .clr_req(clr_req), .busy(busy2));

   // ---------------- reference model ----------------
   int          depth_m [3] = '{128, 128, 100};
   int          mode_m  [3] = '{0, 1, 2};
   int          lat_m   [3] = '{1, 2, 1};
   logic [31:0] mem_m   [3][128];
   int          sweep_m [3];
   logic [31:0] s1_m    [3];
   logic [31:0] s2_m    [3];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            sweep_m[k] = depth_m[k];
            s1_m[k] = 32'h0;
            s2_m[k] = 32'h0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            logic [31:0] old_w, new_w;
            bit          inr;
            s2_m[k] = s1_m[k];
            if (sweep_m[k] > 0) begin
               mem_m[k][depth_m[k] - sweep_m[k]] = 32'h0;
               sweep_m[k]--;
            end else begin
               if (ena) begin
                  inr   = (int'(addr) < depth_m[k]);
                  old_w = inr ? mem_m[k][addr] : 32'h0;
                  new_w = old_w;
                  for (int b = 0; b < 4; b++)
                     if (wea[b]) new_w[8*b +: 8] = din[8*b +: 8];
                  if (inr && wea != 4'h0) mem_m[k][addr] = new_w;
                  if (mode_m[k] == 2 && wea != 4'h0) s1_m[k] = s1_m[k];
                  else if (!inr)                     s1_m[k] = 32'h0;
                  else if (mode_m[k] == 1)           s1_m[k] = new_w;
                  else                               s1_m[k] = old_w;
               end
               if (clr_req) sweep_m[k] = depth_m[k];
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] d [3];
      logic        b [3];
      d[0] = dout0; d[1] = dout1; d[2] = dout2;
      b[0] = busy0; b[1] = busy1; b[2] = busy2;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("douta_u%0d", k), d[k], (lat_m[k] == 1) ? s1_m[k] : s2_m[k]);
         check($sformatf("busy_u%0d", k), {31'h0, b[k]}, {31'h0, (sweep_m[k] > 0)});
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic e, input logic [3:0] w, input int a,
                        input logic [31:0] d, input logic c);
      ena = e; wea = w; addr = 7'(a); din = d; clr_req = c;
      @(negedge clk); #1;
   endtask

   // Counts cycles with busy0 high, issuing full writes that must all be ignored by u0.
   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (!busy0) break;
         n++;
         ena = 1'b1; wea = 4'hF; addr = 7'($urandom_range(0, 127)); din = $urandom; clr_req = 1'b1;
         @(negedge clk); #1;
      end
      ena = 1'b0; wea = 4'h0; clr_req = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!busy0 && !busy1 && !busy2) break;
         drive(0, 4'h0, 0, 32'h0, 0);
      end
      check("wait_idle", {31'h0, busy0 | busy1 | busy2}, 32'h0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      #1;
      check("reset_douta", dout0, 32'h0);
      check("reset_busy", {31'h0, busy0}, 32'h1);
      rst = 1'b0;
      count_busy(n);
      check("busy_len_after_reset", n, 128);

      for (int a = 0; a < 128; a++) begin
         drive(1, 4'h0, a, 32'h0, 0);
         check("read_zero_after_reset", dout0, 32'h0);
      end

      // full write then read, latency 1 vs 2
      drive(1, 4'hF, 2, 32'h12344321, 0);
      drive(1, 4'h0, 7, 32'h0, 0);
      drive(0, 4'h0, 0, 32'h0, 0);
      drive(0, 4'h0, 0, 32'h0, 0);
      drive(1, 4'h0, 2, 32'h0, 0);
      check("read_lat1", dout0, 32'h12344321);
      check("read_lat2_early", dout1, 32'h0);
      drive(0, 4'h0, 0, 32'h0, 0);
      check("read_lat2", dout1, 32'h12344321);

      // partial write and read-during-write modes
      drive(1, 4'hF, 5, 32'hAABBCCDD, 0);
      drive(1, 4'h0, 2, 32'h0, 0);
      drive(1, 4'b0101, 5, 32'h11223344, 0);
      check("rdw_read_first", dout0, 32'hAABBCCDD);
      check("rdw_no_change", dout2, 32'h12344321);
      drive(0, 4'h0, 0, 32'h0, 0);
      check("rdw_write_first", dout1, 32'hAA22CC44);
      drive(1, 4'h0, 5, 32'h0, 0);
      check("merged_word_u0", dout0, 32'hAA22CC44);
      check("merged_word_u2", dout2, 32'hAA22CC44);

      // random traffic
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 127),
               $urandom, $urandom_range(0, 299) == 0);
      wait_idle();

      // fill with address values, then clear on request
      for (int a = 0; a < 128; a++) drive(1, 4'hF, a, a, 0);
      drive(1, 4'h0, 77, 32'h0, 0);
      check("fill_readback", dout0, 32'd77);
      drive(0, 4'h0, 0, 32'h0, 1);
      count_busy(n);
      check("busy_len_clr_req", n, 128);
      check("douta_held_in_sweep", dout0, 32'd77);
      wait_idle();
      for (int a = 0; a < 128; a++) begin
         drive(1, 4'h0, a, 32'h0, 0);
         check("read_zero_after_clear", dout0, 32'h0);
      end

      // reset in the middle of a sweep
      drive(1, 4'hF, 1, 32'h5A5A5A5A, 0);
      drive(1, 4'h0, 1, 32'h0, 0);
      drive(0, 4'h0, 0, 32'h0, 0);
      check("pre_abort_douta", dout0, 32'h5A5A5A5A);
      drive(0, 4'h0, 0, 32'h0, 1);
      repeat (60) drive(0, 4'h0, 0, 32'h0, 0);
      rst = 1'b1;
      #1;
      check("async_rst_douta_u0", dout0, 32'h0);
      check("async_rst_douta_u1", dout1, 32'h0);
      check("async_rst_busy", {31'h0, busy0}, 32'h1);
      @(negedge clk); @(negedge clk); #1;
      rst = 1'b0;
      count_busy(n);
      check("busy_len_after_abort", n, 128);
      wait_idle();

      // out-of-range access on the 100-word instance
      for (int a = 0; a < 128; a++) drive(1, 4'hF, a, 32'h01010101 * a ^ 32'hC3C3_0000, 0);
      drive(1, 4'hF, 120, 32'hCAFEF00D, 0);
      drive(1, 4'h0, 120, 32'h0, 0);
      check("oor_read_u2", dout2, 32'h0);
      check("inrange_read_u0", dout0, 32'hCAFEF00D);
      for (int a = 0; a < 100; a++) begin
         drive(1, 4'h0, a, 32'h0, 0);
         check("oor_no_alias_u2", dout2, 32'h01010101 * a ^ 32'hC3C3_0000);
      end
      drive(0, 4'h0, 0, 32'h0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
